// File: rtl/decode_stage.sv
// decode_stage: register file with two async read ports, write-back source select and immediate extension
module decode_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [31:0]       Instr,
  input  logic              RF_WrEn,
  input  logic              RF_B_SEL,
  input  logic              RF_WrData_SEL,
  input  logic [1:0]        Imm_SEL,
  input  logic [DATA_W-1:0] ALU_out,
  input  logic [DATA_W-1:0] MEM_out,
  output logic [DATA_W-1:0] RF_A,
  output logic [DATA_W-1:0] RF_B,
  output logic [31:0]       Immed
);
  logic [DATA_W-1:0] regs [REG_CNT];
  logic [4:0] rs, rd, rt, b_addr;
  logic [15:0] imm;
  logic [31:0] sext;
  logic [DATA_W-1:0] wr_data;
  logic unused_opcode;
  assign rs = Instr[25:21];
  assign rd = Instr[20:16];
  assign rt = Instr[15:11];
  assign imm = Instr[15:0];
  assign unused_opcode = ^Instr[31:26];
  assign b_addr = RF_B_SEL ? rd : rt;
  assign wr_data = RF_WrData_SEL ? MEM_out : ALU_out;
  assign sext = {{16{imm[15]}}, imm};
  // R0 reads as zero regardless of what its storage holds
  always_comb begin
    RF_A = (rs == 5'd0) ? '0 : regs[rs];
    RF_B = (b_addr == 5'd0) ? '0 : regs[b_addr];
    Immed = (Imm_SEL == 2'b00) ? sext :
            (Imm_SEL == 2'b01) ? {16'h0000, imm} :
            (Imm_SEL == 2'b10) ? {imm, 16'h0000} : {sext[29:0], 2'b00};
  end
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else if (RF_WrEn && rd != 5'd0) begin
      regs[rd] <= wr_data;
    end
  end
endmodule
